// File: rtl/tone_period_meter_if.sv
// Tone period meter bus: tone input plus measured-period results.
interface tone_period_meter_if #(
  parameter int unsigned CNT_W = 24
);
  logic             tone_in;
  logic [CNT_W-1:0] period;
  logic             period_valid;
  logic             locked;
  logic             timeout;

  // Producer of the tone / consumer of the results
  modport master (
    output tone_in,
    input  period,
    input  period_valid,
    input  locked,
    input  timeout
  );

  // The meter itself
  modport slave (
    input  tone_in,
    output period,
    output period_valid,
    output locked,
    output timeout
  );
endinterface

// File: rtl/tone_period_meter.sv
// Measures the rising-edge-to-rising-edge period of an asynchronous tone in
// clk cycles, flags lock between consecutive periods and loss of signal.
module tone_period_meter #(
  parameter int unsigned      CNT_W   = 24,
  parameter logic [CNT_W-1:0] TIMEOUT = CNT_W'(2_000_000),
  parameter logic [CNT_W-1:0] TOL     = CNT_W'(2)
) (
  input  logic                clk,
  input  logic                rst,
  tone_period_meter_if.slave  bus
);

  typedef enum logic {
    IDLE,
    MEASURE
  } state_t;

  state_t           state_q, state_d;
  logic             s1, s2, s3;
  logic             rise;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] diff;

  logic [CNT_W-1:0] period_q, period_d;
  logic             pv_q, pv_d;
  logic             locked_q, locked_d;
  logic             timeout_q, timeout_d;
  logic [CNT_W-1:0] prev_q, prev_d;
  logic             have_prev_q, have_prev_d;

  // Two-flop synchronizer plus history flop for rising-edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= bus.tone_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise = s2 & ~s3;

  // Cycle counter: restarts at 1 on each rising edge, saturates at TIMEOUT
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (rise) begin
      cnt <= CNT_W'(1);
    end else if (cnt != TIMEOUT) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Unsigned distance between the current count and the previous period
  assign diff = (cnt >= prev_q) ? (cnt - prev_q) : (prev_q - cnt);

  // State and result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      period_q    <= '0;
      pv_q        <= 1'b0;
      locked_q    <= 1'b0;
      timeout_q   <= 1'b0;
      prev_q      <= '0;
      have_prev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      period_q    <= period_d;
      pv_q        <= pv_d;
      locked_q    <= locked_d;
      timeout_q   <= timeout_d;
      prev_q      <= prev_d;
      have_prev_q <= have_prev_d;
    end
  end

  // Next-state and result logic; a rise always beats a same-cycle timeout
  always_comb begin
    state_d     = state_q;
    period_d    = period_q;
    pv_d        = 1'b0;
    locked_d    = locked_q;
    timeout_d   = timeout_q;
    prev_d      = prev_q;
    have_prev_d = have_prev_q;
    case (state_q)
      IDLE: begin
        // First edge only arms the measurement
        if (rise) begin
          have_prev_d = 1'b0;
          timeout_d   = 1'b0;
          state_d     = MEASURE;
        end
      end
      MEASURE: begin
        if (rise) begin
          period_d    = cnt;
          pv_d        = 1'b1;
          locked_d    = have_prev_q && (diff <= TOL);
          prev_d      = cnt;
          have_prev_d = 1'b1;
          timeout_d   = 1'b0;
        end else if (cnt == TIMEOUT) begin
          state_d     = IDLE;
          timeout_d   = 1'b1;
          locked_d    = 1'b0;
          have_prev_d = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.period       = period_q;
  assign bus.period_valid = pv_q;
  assign bus.locked       = locked_q;
  assign bus.timeout      = timeout_q;

endmodule

// File: tb/tb_tone_period_meter.sv
// Self-checking bench for tone_period_meter: event-timestamp model plus
// directed literal expectations.
module tb_tone_period_meter;

  localparam int unsigned CNT_W   = 24;
  localparam int          TIMEOUT = 5000;
  localparam int          TOL     = 2;

  logic clk;
  logic rst;
  logic tone;

  tone_period_meter_if #(.CNT_W(CNT_W)) bus ();

  assign bus.tone_in = tone;

  tone_period_meter #(
    .CNT_W   (CNT_W),
    .TIMEOUT (CNT_W'(TIMEOUT)),
    .TOL     (CNT_W'(TOL))
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;

  // Edge counter: cyc is the index of the most recent rising clk edge
  int cyc = 0;
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  // Cycle (edge index) after which the tone went 0->1
  bit rise_at [int];
  int last_rise = 0;

  // Captured DUT pulses
  int cap_per  [$];
  int cap_lock [$];
  int cap_cyc  [$];

  // Loss-of-signal capture
  int to_cyc    = -1;
  int to_locked = -1;
  int to_period = -1;
  bit prev_to   = 1'b0;

  // Model state, expressed in edge timestamps
  int m_armed, m_last, m_period, m_prev, m_have, m_locked, m_timeout, m_pv;
  int m_p, m_d;
  bit rst_e;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic set_tone(input bit v);
    @(posedge clk);
    #1;
    if (v && !tone) begin
      rise_at[cyc] = 1'b1;
      last_rise = cyc;
    end
    tone = v;
  endtask

  task automatic pulse(input int hi, input int lo);
    for (int i = 0; i < hi; i++) set_tone(1'b1);
    for (int i = 0; i < lo; i++) set_tone(1'b0);
  endtask

  task automatic clr_cap();
    cap_per.delete();
    cap_lock.delete();
    cap_cyc.delete();
  endtask

  // Model update and per-cycle comparison, sampled 2 time units after the edge
  always @(posedge clk) begin
    rst_e = rst;
    #2;
    if (rst_e) begin
      m_armed = 0; m_last = 0; m_period = 0; m_prev = 0;
      m_have = 0; m_locked = 0; m_timeout = 0; m_pv = 0;
      rise_at.delete();
    end else begin
      m_pv = 0;
      // A tone rise after edge r is reported at edge r+3
      if (rise_at.exists(cyc - 3)) begin
        if (m_armed != 0) begin
          m_p = cyc - m_last;
          m_d = (m_p > m_prev) ? (m_p - m_prev) : (m_prev - m_p);
          m_pv = 1;
          m_period = m_p;
          m_locked = (m_have != 0 && m_d <= TOL) ? 1 : 0;
          m_prev = m_p;
          m_have = 1;
        end else begin
          m_armed = 1;
          m_have = 0;
        end
        m_timeout = 0;
        m_last = cyc;
      end else if (m_armed != 0 && (cyc - m_last) == TIMEOUT) begin
        m_armed = 0;
        m_timeout = 1;
        m_locked = 0;
        m_have = 0;
      end
    end
    chk("period_valid", int'(bus.period_valid), m_pv);
    chk("period", int'(bus.period), m_period);
    chk("locked", int'(bus.locked), m_locked);
    chk("timeout", int'(bus.timeout), m_timeout);
    if (bus.period_valid) begin
      cap_per.push_back(int'(bus.period));
      cap_lock.push_back(int'(bus.locked));
      cap_cyc.push_back(cyc);
    end
    if (bus.timeout && !prev_to) begin
      to_cyc = cyc;
      to_locked = int'(bus.locked);
      to_period = int'(bus.period);
    end
    prev_to = bus.timeout;
  end

  int r18, r19, r_fast;

  initial begin
    tone = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_period", int'(bus.period), 0);
    chk("reset_valid", int'(bus.period_valid), 0);
    chk("reset_locked", int'(bus.locked), 0);
    chk("reset_timeout", int'(bus.timeout), 0);
    rst = 1'b0;
    repeat (5) set_tone(1'b0);

    // Steady 1264 tone, then pitch step to 632
    clr_cap();
    repeat (4) pulse(632, 632);
    repeat (3) pulse(316, 316);
    chk("steady_count", cap_per.size(), 6);
    for (int i = 0; i < 4; i++) begin
      chk("steady_period", cap_per[i], 1264);
      chk("steady_locked", cap_lock[i], (i == 0) ? 0 : 1);
    end
    chk("step_period", cap_per[4], 632);
    chk("step_locked", cap_lock[4], 0);
    chk("step2_period", cap_per[5], 632);
    chk("step2_locked", cap_lock[5], 1);

    // Tolerance edge: 1000/1002 locks, 1000/1003 does not
    clr_cap();
    pulse(500, 500); pulse(501, 501); pulse(500, 500); pulse(501, 501);
    pulse(500, 500); pulse(501, 502); pulse(500, 500); pulse(501, 502);
    chk("tol_count", cap_per.size(), 8);
    chk("tol2_period", cap_per[2], 1002);
    chk("tol2_locked", cap_lock[2], 1);
    chk("tol4_locked", cap_lock[4], 1);
    chk("tol3_period", cap_per[6], 1003);
    chk("tol3_locked", cap_lock[6], 0);

    // Loss of signal after lock
    clr_cap();
    repeat (3) pulse(500, 500);
    r18 = last_rise;
    chk("los_lock_count", cap_per.size(), 3);
    chk("los_lock_locked", cap_lock[2], 1);
    repeat (5000) set_tone(1'b0);
    chk("los_timeout_cycle", to_cyc, r18 + 3 + TIMEOUT);
    chk("los_locked_drop", to_locked, 0);
    chk("los_period_hold", to_period, 1000);
    chk("los_timeout_high", int'(bus.timeout), 1);

    // Recovery edge clears timeout three cycles after it is driven
    clr_cap();
    set_tone(1'b1);
    r19 = last_rise;
    @(posedge clk);
    @(posedge clk);
    #2;
    chk("rec_timeout_still", int'(bus.timeout), 1);
    @(posedge clk);
    #2;
    chk("rec_timeout_clear", int'(bus.timeout), 0);
    chk("rec_no_valid", int'(bus.period_valid), 0);
    repeat (496) set_tone(1'b1);
    repeat (500) set_tone(1'b0);
    pulse(500, 500);
    chk("rec_count", cap_per.size(), 1);
    chk("rec_period", cap_per[0], 1000);
    chk("rec_locked", cap_lock[0], 0);

    // Asynchronous reset partway through a period
    repeat (200) set_tone(1'b1);
    chk("pre_rst_period", int'(bus.period), 1000);
    @(posedge clk);
    #3;
    rst = 1'b1;
    tone = 1'b0;
    #1;
    chk("async_period", int'(bus.period), 0);
    chk("async_valid", int'(bus.period_valid), 0);
    chk("async_locked", int'(bus.locked), 0);
    chk("async_timeout", int'(bus.timeout), 0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    clr_cap();
    repeat (3) set_tone(1'b0);
    pulse(400, 400);
    pulse(400, 400);
    chk("post_rst_count", cap_per.size(), 1);
    chk("post_rst_period", cap_per[0], 800);
    chk("post_rst_locked", cap_lock[0], 0);

    // Fastest tone and first-edge latency
    clr_cap();
    pulse(1, 1);
    r_fast = last_rise;
    repeat (7) pulse(1, 1);
    repeat (10) set_tone(1'b0);
    chk("fast_count", cap_per.size(), 8);
    chk("fast_latency", cap_cyc[0], r_fast + 3);
    chk("fast_first_period", cap_per[0], 800);
    for (int i = 1; i < 8; i++) chk("fast_period", cap_per[i], 2);
    chk("fast_spacing", cap_cyc[7] - cap_cyc[1], 12);
    chk("fast_locked0", cap_lock[1], 0);
    chk("fast_locked1", cap_lock[2], 1);

    repeat (3) @(posedge clk);
    #3;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
